stall_buffer: RTL and testbench

STALL_BUFFER -- requirements
Module: stall_buffer

---
 rtl/stall_buffer.sv | 115 +++++++++++
 tb/tb_stall_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stall_buffer.sv
// stall_buffer: registered output stage with a skid FIFO behind it.
// While the downstream is frozen (stall_in=1) the output register holds and
// incoming beats are parked in the FIFO. When the stall lifts, the FIFO drains
// one beat per cycle ahead of any new input, so beat order is preserved.
// full_to_mgmt asserts one slot early because the stall it triggers arrives
// through a register and so takes effect one cycle late.
module stall_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     stall_in,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     full_to_mgmt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] NEARLY_C  = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]       count_reg, count_next;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic                overflow_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                drop;

    // Decide push/pop/drop for this cycle and the resulting occupancy/state.
    // Outside HOLD the state alone tells whether the FIFO holds anything
    // (DRAIN <=> count>0); in HOLD that is lost, so fall back to the count.
    always_comb begin
        fifo_empty = (state_reg == HOLD) ? (count_reg == '0) : (state_reg == EMPTY);
        fifo_full  = (count_reg == DEPTH_C);
        pop        = !stall_in && !fifo_empty;
        // When not stalled and empty, the beat bypasses the FIFO entirely.
        push       = in_valid && (stall_in ? !fifo_full : !fifo_empty);
        drop       = in_valid && stall_in && fifo_full;
        count_next = count_reg + CW'(push) - CW'(pop);
        if (stall_in) begin
            state_next = HOLD;
        end else if (count_next != '0) begin
            state_next = DRAIN;
        end else begin
            state_next = EMPTY;
        end
    end

    // FIFO storage; contents need no reset because the pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // State, pointers, occupancy, sticky overflow and the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (!stall_in) begin
                if (fifo_empty) begin
                    out_valid_reg <= in_valid;
                    out_data_reg  <= in_data;
                end else begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= mem[rd_ptr_reg];
                end
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign full_to_mgmt = (count_reg >= NEARLY_C);

endmodule

// File: tb/tb_stall_buffer.sv
// Testbench for stall_buffer (DATA_W=8, DEPTH=4): directed scenarios followed
// by random traffic, every cycle compared against a queue-based model.
module tb_stall_buffer;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          stall_in;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          full_to_mgmt;
    logic [2:0]    count;
    logic          overflow;

    int compared;
    int mismatched;

    // Reference model: a queue of parked beats plus the visible output register.
    logic [DW-1:0] q[$];
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic          m_ovf;

    stall_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .stall_in     (stall_in),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .full_to_mgmt (full_to_mgmt),
        .count        (count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".out_data"},  32'(out_data),  32'(m_od));
        check({tag, ".count"},     32'(count),     32'(q.size()));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".full"},      32'(full_to_mgmt), 32'(q.size() >= DP - 1));
        $display("[%0t] %s iv=%0b id=%02h st=%0b -> ov=%0b od=%02h cnt=%0d ovf=%0b full=%0b",
                 $time, tag, in_valid, in_data, stall_in, out_valid, out_data, count, overflow, full_to_mgmt);
    endtask

    // One clock: drive inputs, apply the rules to the model at the edge, compare.
    task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] id, input logic st);
        in_valid = iv;
        in_data  = id;
        stall_in = st;
        @(posedge clk);
        if (!st) begin
            if (q.size() == 0) begin
                m_ov = iv;
                m_od = id;
            end else begin
                m_od = q.pop_front();
                m_ov = 1'b1;
                if (iv) q.push_back(id);
            end
        end else if (iv) begin
            if (q.size() < DP) q.push_back(id);
            else m_ovf = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic model_clear();
        q.delete();
        m_ov  = 1'b0;
        m_od  = '0;
        m_ovf = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        stall_in   = 1'b0;
        model_clear();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("post_reset");

        // Pass-through: one-cycle latency, FIFO untouched.
        cycle("pass", 1'b1, 8'h11, 1'b0);
        check("pass.first", 32'(out_data), 32'h11);
        cycle("pass", 1'b1, 8'h22, 1'b0);
        cycle("pass", 1'b1, 8'h33, 1'b0);
        check("pass.third", 32'(out_data), 32'h33);
        cycle("pass", 1'b0, 8'h00, 1'b0);

        // Skid: three beats parked under stall, then drained in order.
        cycle("skid", 1'b1, 8'hA1, 1'b1);
        cycle("skid", 1'b1, 8'hA2, 1'b1);
        cycle("skid", 1'b1, 8'hA3, 1'b1);
        check("skid.full", 32'(full_to_mgmt), 32'h1);
        cycle("skid_drain", 1'b0, 8'h00, 1'b0);
        check("skid.head", 32'(out_data), 32'hA1);
        cycle("skid_drain", 1'b0, 8'h00, 1'b0);
        cycle("skid_drain", 1'b0, 8'h00, 1'b0);
        check("skid.empty", 32'(count), 32'h0);
        cycle("idle", 1'b0, 8'h00, 1'b0);

        // Simultaneous push and pop keeps the count.
        cycle("pp_fill", 1'b1, 8'h01, 1'b1);
        cycle("pp_fill", 1'b1, 8'h02, 1'b1);
        cycle("pp", 1'b1, 8'h03, 1'b0);
        check("pp.out", 32'(out_data), 32'h01);
        check("pp.count", 32'(count), 32'h2);
        cycle("pp", 1'b0, 8'h00, 1'b0);
        cycle("pp", 1'b0, 8'h00, 1'b0);
        check("pp.last", 32'(out_data), 32'h03);
        cycle("idle", 1'b0, 8'h00, 1'b0);

        // Overflow: fifth beat under stall is dropped; the flag is sticky.
        for (int i = 0; i < 5; i++) cycle("ovf", 1'b1, 8'(8'h10 + i), 1'b1);
        check("ovf.count", 32'(count), 32'h4);
        check("ovf.flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cycle("ovf_drain", 1'b0, 8'h00, 1'b0);
            assert (!(out_valid && out_data == 8'h14)) else begin
                mismatched++;
                $error("FAIL ovf.dropped: observed %0h expected not 14", out_data);
            end
            compared++;
        end
        check("ovf.sticky", 32'(overflow), 32'h1);

        // Wrap: repeated stall/drain bursts walk the pointers around.
        for (int r = 0; r < 10; r++) begin
            for (int b = 0; b < 3; b++) cycle("wrap", 1'b1, 8'(r * 16 + b), 1'b1);
            for (int b = 0; b < 4; b++) cycle("wrap_drain", 1'b0, 8'h00, 1'b0);
        end

        // Mid-operation reset: asynchronous clear, nothing stale afterwards.
        cycle("rst_fill", 1'b1, 8'hC1, 1'b1);
        cycle("rst_fill", 1'b1, 8'hC2, 1'b1);
        cycle("rst_fill", 1'b1, 8'hC3, 1'b1);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        stall_in = 1'b0;
        #1;
        model_clear();
        check_all("rst_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("rst_release");
        for (int i = 0; i < 4; i++) cycle("rst_after", 1'b0, 8'h00, 1'b0);

        // Random traffic with runs of stall.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 99) < 70),
                  8'($urandom), ($urandom_range(0, 99) < 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
